// File: rtl/mux6_rr_arbiter.sv
// Six-input round-robin arbiter with a registered data mux and a valid/ready output.
// Each transfer walks IDLE -> BUSY -> DONE; the winner's data is captured at grant
// and held until the consumer accepts it, then a one-cycle ack goes back.
module mux6_rr_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    output logic [5:0]       ack,
    output logic [2:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int unsigned NREQ = 6;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] NO_GRANT = 3'b111;
    localparam logic [2:0] PTR_RST  = 3'd5;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [2:0]       ptr;
    logic [2:0]       ptr_nxt;
    logic [2:0]       sel_nxt;
    logic [5:0]       ack_nxt;
    logic [WIDTH-1:0] out_data_nxt;
    logic             out_valid_nxt;
    logic             busy_nxt;

    logic [WIDTH-1:0] din [NREQ];
    logic [3:0]       cand;
    logic             found;
    logic [2:0]       winner;

    assign din[0] = in0;
    assign din[1] = in1;
    assign din[2] = in2;
    assign din[3] = in3;
    assign din[4] = in4;
    assign din[5] = in5;

    // Rotating-priority search: first requester after ptr, wrapping 5 -> 0.
    always_comb begin
        cand   = 4'd0;
        found  = 1'b0;
        winner = 3'd0;
        for (int k = 1; k <= 6; k++) begin
            cand = 4'(ptr) + 4'(k);
            if (cand >= 4'd6) begin
                cand = cand - 4'd6;
            end
            if (!found && req[cand[2:0]]) begin
                found  = 1'b1;
                winner = cand[2:0];
            end
        end
    end

    // Next-state and next-output logic for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        sel_nxt       = sel;
        ack_nxt       = ack;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;
        busy_nxt      = busy;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt     = BUSY;
                    sel_nxt       = winner;
                    out_data_nxt  = din[winner];
                    out_valid_nxt = 1'b1;
                    busy_nxt      = 1'b1;
                end
            end
            BUSY: begin
                if (out_valid && out_ready) begin
                    state_nxt     = DONE;
                    out_valid_nxt = 1'b0;
                    ack_nxt       = 6'b000001 << sel;
                    ptr_nxt       = sel;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                ack_nxt   = 6'b000000;
                sel_nxt   = NO_GRANT;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt     = IDLE;
                ack_nxt       = 6'b000000;
                sel_nxt       = NO_GRANT;
                out_valid_nxt = 1'b0;
                busy_nxt      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset wins over any in-flight transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= PTR_RST;
            sel       <= NO_GRANT;
            ack       <= 6'b000000;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            sel       <= sel_nxt;
            ack       <= ack_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mux6_rr_arbiter.sv
// Bench for mux6_rr_arbiter: directed scenarios followed by random traffic.
// A transaction-level model queues each expected grant; a monitor compares the
// DUT outputs against the queue head and the model's ack/sel expectations.
module tb_mux6_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  req;
    logic [31:0] din [6];
    logic [5:0]  ack;
    logic [2:0]  sel;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] data;
    } xfer_t;

    // Model state: pending transfers, last completed index, DONE-cycle flag.
    xfer_t      sb [$];
    int         m_last = 5;
    bit         m_done = 1'b0;
    logic [5:0] m_ack  = 6'b0;
    logic [2:0] m_cur  = 3'b111;

    mux6_rr_arbiter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in0       (din[0]),
        .in1       (din[1]),
        .in2       (din[2]),
        .in3       (din[3]),
        .in4       (din[4]),
        .in5       (din[5]),
        .ack       (ack),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one pending grant at a time, round robin after last completion.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            m_last = 5;
            m_done = 1'b0;
            m_ack  = 6'b0;
            m_cur  = 3'b111;
        end else if (m_done) begin
            m_done = 1'b0;
            m_ack  = 6'b0;
            m_cur  = 3'b111;
        end else if (sb.size() != 0) begin
            if (out_ready) begin
                m_last = int'(sb[0].sel);
                m_ack  = 6'b0;
                m_ack[m_last] = 1'b1;
                void'(sb.pop_front());
                m_done = 1'b1;
            end
        end else if (req != 6'b0) begin
            for (int k = 1; k <= 6; k++) begin
                int idx;
                idx = (m_last + k) % 6;
                if (req[idx]) begin
                    xfer_t t;
                    t.sel  = 3'(idx);
                    t.data = din[idx];
                    sb.push_back(t);
                    m_cur = 3'(idx);
                    break;
                end
            end
        end
    end

    // Monitor: compare DUT outputs with the model between clock edges.
    always @(negedge clk) begin
        if (checking) begin
            chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            chk("busy", 32'(busy), 32'((sb.size() != 0) || m_done));
            chk("sel", 32'(sel), 32'(m_cur));
            chk("ack", 32'(ack), 32'(m_ack));
            chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
            if (out_valid && sb.size() != 0) begin
                chk("out_data", out_data, sb[0].data);
            end
        end
    end

    // Advance one cycle; requesters drop req on seeing their ack.
    task automatic step();
        @(negedge clk);
        req = req & ~ack;
    endtask

    initial begin
        int n;
        int acks;
        logic [2:0] order [6];

        rst = 1'b1;
        req = 6'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) din[i] = 32'h0;
        @(negedge clk);
        checking = 1'b1;
        chk("reset_sel", 32'(sel), 32'h7);
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_data", out_data, 32'h0);
        rst = 1'b0;

        // Single request, single transfer
        din[0] = 32'hDEADBEEF;
        req = 6'b000001;
        out_ready = 1'b1;
        step();
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_sel", 32'(sel), 32'h0);
        chk("t1_data", out_data, 32'hDEADBEEF);
        step();
        chk("t1_ack", 32'(ack), 32'h01);
        chk("t1_valid_done", 32'(out_valid), 32'h0);
        step();
        chk("t1_ack_clear", 32'(ack), 32'h0);
        chk("t1_sel_idle", 32'(sel), 32'h7);
        chk("t1_data_hold", out_data, 32'hDEADBEEF);

        // All six requesting after reset: order 0..5, one ack per 3 cycles
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) din[i] = 32'h1000 + 32'(i);
        req = 6'b111111;
        n = 0;
        acks = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (out_valid) begin
                if (n < 6) order[n] = sel;
                n++;
            end
            if (ack != 6'b0) acks++;
        end
        chk("t2_grants", 32'(n), 32'd6);
        chk("t2_acks", 32'(acks), 32'd6);
        for (int i = 0; i < 6; i++) chk("t2_order", 32'(order[i]), 32'(i));

        // Stalled consumer; data and withdrawn req must not disturb the grant
        din[2] = 32'hA5A5_0002;
        req = 6'b000100;
        out_ready = 1'b0;
        step();
        chk("t3_sel", 32'(sel), 32'h2);
        req = 6'b000000;
        for (int c = 0; c < 10; c++) begin
            din[2] = 32'($urandom);
            step();
            chk("t3_hold_valid", 32'(out_valid), 32'h1);
            chk("t3_hold_data", out_data, 32'hA5A5_0002);
            chk("t3_no_ack", 32'(ack), 32'h0);
        end
        out_ready = 1'b1;
        step();
        chk("t3_ack", 32'(ack), 32'h04);
        step();

        // Pointer wrap past 5, then sole requester regranted
        req = 6'b010000;
        step(); step(); step();
        req = 6'b010001;
        step();
        chk("t4_wrap_sel", 32'(sel), 32'h0);
        step(); step(); step();
        chk("t4_regrant_sel", 32'(sel), 32'h4);
        step(); step();

        // Reset while busy aborts without ack
        req = 6'b001000;
        out_ready = 1'b0;
        step();
        chk("t5_sel", 32'(sel), 32'h3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_valid", 32'(out_valid), 32'h0);
        chk("t5_ack", 32'(ack), 32'h0);
        chk("t5_sel_idle", 32'(sel), 32'h7);
        req = 6'b001001;
        step();
        chk("t5_first_grant", 32'(sel), 32'h0);
        out_ready = 1'b1;
        step(); step();

        // Random traffic
        for (int c = 0; c < 1000; c++) begin
            step();
            req = 6'($urandom) & 6'($urandom) & ~ack;
            for (int i = 0; i < 6; i++) din[i] = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 149) == 0);
        end

        rst = 1'b0;
        req = 6'b0;
        out_ready = 1'b1;
        repeat (6) step();
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux6_rr_arbiter.md
MUX6_RR_ARBITER -- requirements
Module: mux6_rr_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, data width of every requester input and of out_data.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: req  input  6  per-requester request, bit i = requester i.
REQ-006 Port: in0..in5  input  WIDTH each  requester data words.
REQ-007 Port: ack  output  6  one-hot completion pulse, bit i = requester i.
REQ-008 Port: sel  output  3  current grant index 0-5; 3'b111 = no grant.
REQ-009 Port: out_data  output  WIDTH  registered data of granted requester.
REQ-010 Port: out_valid  output  1  out_data valid toward consumer.
REQ-011 Port: out_ready  input  1  consumer accepts out_data.
REQ-012 Port: busy  output  1  high in BUSY or DONE state.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-014 IDLE: if req==0, stay; else grant the first requester with req high, searching cyclically from ptr+1 (mod 6), where ptr = last completed index.
REQ-015 On the grant edge, the block SHALL register sel <= winner, out_data <= in[winner], out_valid <= 1 and enter BUSY; latency from req sampled high to out_valid high is 1 cycle.
REQ-016 BUSY: out_data and sel SHALL hold constant; input data changes and req changes (including withdrawal) SHALL be ignored.
REQ-017 BUSY with out_valid & out_ready at an edge: out_valid <= 0, ack[sel] <= 1, ptr <= sel, enter DONE.
REQ-018 BUSY with out_ready low: stay indefinitely, no timeout.
REQ-019 DONE: exactly one cycle, ack one-hot on sel, out_valid 0; next state IDLE with ack <= 0 and sel <= 3'b111.
REQ-020 Requester contract: a requester SHALL deassert req at the edge on which it samples ack high; the block arbitrates on req as sampled in IDLE.
REQ-021 Maximum throughput: one transfer per 3 cycles (IDLE, BUSY, DONE) when out_ready is held high.
REQ-022 sel values 6 and 7 SHALL never appear except 3'b111 as idle code; ack SHALL never have more than one bit set.
REQ-023 ptr wraps 5 -> 0; with all six requesting continuously, grants SHALL cycle 0,1,2,3,4,5,0,...
REQ-024 A requester that is the only one requesting SHALL be re-granted regardless of ptr.
REQ-025 out_data SHALL retain its last value outside BUSY; consumers qualify with out_valid only.

Reset
REQ-026 While rst is high at an edge: state <= IDLE, ptr <= 5, sel <= 3'b111, ack <= 0, out_valid <= 0, out_data <= 0, busy <= 0.
REQ-027 Reset asserted in BUSY or DONE SHALL abort the transfer with no ack pulse; rst has priority over every other event.
REQ-028 After reset release the first grant among simultaneous requests SHALL go to requester 0.

Verification
REQ-029 Reset then req=6'b000001, in0=32'hDEADBEEF, out_ready=1 -> next cycle out_valid=1, sel=0, out_data=DEADBEEF; then ack=6'b000001 for one cycle; sel returns 3'b111.
REQ-030 req=6'b111111 held (each drops on its ack), out_ready=1 -> grant order 0,1,2,3,4,5, one ack per 3 cycles, no double-ack.
REQ-031 Grant to 2 with out_ready=0 for 10 cycles, in2 changed and req[2] dropped meanwhile -> out_valid stays 1, out_data = in2 value at grant, no ack until out_ready=1.
REQ-032 ptr=4 (last ack on 4), req=6'b010001 -> grant 0 (wrap past 5); then with req[4] only -> grant 4.
REQ-033 rst pulsed 1 cycle while BUSY on requester 3 -> out_valid=0, ack=0, sel=3'b111 next cycle; next req=6'b001001 grants 0.
REQ-034 Random req/out_ready, in0..in5 random, 1000 cycles -> scoreboard: every accepted out_data equals in[sel] at grant, ack one-hot, sel never 6.
